// File: rtl/state_squeezer_if.sv
// Capture and output-stream signals of the Keccak squeeze stage.
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid (load / out_valid) and ready (load_ready / out_ready) are both high.
// The payload is held stable while valid is high and ready is low.
interface state_squeezer_if #(parameter int N = 64);
  logic                     load;
  logic                     load_ready;
  logic [4:0][4:0][N-1:0]   state_in;
  logic [2:0]               c_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic [N-1:0]             out_data;
  logic [7:0]               out_keep;
  logic                     out_last;

  modport master (
    input  load, state_in, c_mode, out_ready,
    output load_ready, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    output load, state_in, c_mode, out_ready,
    input  load_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/state_squeezer.sv
// Keccak squeeze stage: captures the 5x5 lane state and streams lanes in
// string order (lane k = state_in[k/5][k%5]) as 64-bit words.
module state_squeezer #(
  parameter int N = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  state_squeezer_if.master    sq,
  output logic                done,
  output logic                more,
  output logic                mode_err,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] lanes [25];
  logic [4:0]   idx;
  logic [4:0]   w_last;
  logic [7:0]   keep_last;
  logic         shake;

  logic         dec_ok;
  logic [4:0]   dec_wl;
  logic [7:0]   dec_keep;
  logic         dec_shake;
  logic [4:0]   nxt;
  logic         accept;

  // Decode stores W-1 so the last-word compare needs no subtraction.
  always_comb begin
    dec_ok    = 1'b1;
    dec_wl    = 5'd3;
    dec_keep  = 8'hFF;
    dec_shake = 1'b0;
    case (sq.c_mode)
      3'd0: begin dec_wl = 5'd3;  dec_keep = 8'h0F; end
      3'd1: begin dec_wl = 5'd20; dec_shake = 1'b1; end
      3'd2: begin dec_wl = 5'd16; dec_shake = 1'b1; end
      3'd3: dec_wl = 5'd3;
      3'd4: dec_wl = 5'd5;
      3'd5: dec_wl = 5'd7;
      default: dec_ok = 1'b0;
    endcase
  end

  assign nxt       = idx + 5'd1;
  assign accept    = (state == IDLE) && sq.load && dec_ok;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          lanes[5*i+j] <= sq.state_in[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= 5'd0;
      w_last        <= 5'd0;
      keep_last     <= 8'h00;
      shake         <= 1'b0;
      sq.load_ready <= 1'b1;
      sq.out_valid  <= 1'b0;
      sq.out_data   <= '0;
      sq.out_keep   <= 8'h00;
      sq.out_last   <= 1'b0;
      done          <= 1'b0;
      more          <= 1'b0;
      mode_err      <= 1'b0;
    end else begin
      mode_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sq.load && !dec_ok) begin
            mode_err <= 1'b1;
          end else if (accept) begin
            state         <= STREAM;
            idx           <= 5'd0;
            w_last        <= dec_wl;
            keep_last     <= dec_keep;
            shake         <= dec_shake;
            sq.load_ready <= 1'b0;
            sq.out_valid  <= 1'b1;
            sq.out_data   <= sq.state_in[0][0];
            sq.out_keep   <= 8'hFF;
            sq.out_last   <= 1'b0;
          end
        end
        STREAM: begin
          if (sq.out_ready) begin
            if (idx == w_last) begin
              state        <= DONE;
              sq.out_valid <= 1'b0;
              sq.out_data  <= '0;
              sq.out_keep  <= 8'h00;
              sq.out_last  <= 1'b0;
              done         <= 1'b1;
              more         <= shake;
            end else begin
              idx         <= nxt;
              sq.out_data <= lanes[nxt];
              sq.out_last <= (nxt == w_last);
              sq.out_keep <= (nxt == w_last) ? keep_last : 8'hFF;
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          idx           <= 5'd0;
          done          <= 1'b0;
          more          <= 1'b0;
          sq.load_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_squeezer.sv
// Directed bench for state_squeezer: per-feature tasks with inline checks.
module tb_state_squeezer;
  logic clk;
  logic rst_n;
  logic done, more, mode_err;
  logic [1:0] state_dbg;
  int n_vec;
  int n_err;

  state_squeezer_if #(.N(64)) sq ();

  state_squeezer #(.N(64)) dut (
    .clk(clk), .rst_n(rst_n), .sq(sq),
    .done(done), .more(more), .mode_err(mode_err), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] lane_val(input int k);
    return 64'h0101_0101_0101_0101 * 64'(k);
  endfunction

  task automatic fill_state(input logic [63:0] mask);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        sq.state_in[i][j] = lane_val(5*i+j) ^ mask;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_load(input logic [2:0] mode);
    sq.c_mode = mode;
    sq.load = 1'b1;
    tick();
    sq.load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sq.load = 1'b0; sq.out_ready = 1'b1; sq.c_mode = 3'd0;
    fill_state(64'h0);
    tick(); tick();
    n_vec++; if (sq.load_ready !== 1'b1) begin n_err++; $display("FAIL rst_load_ready got %b want 1", sq.load_ready); end
    n_vec++; if (sq.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", sq.out_valid); end
    n_vec++; if (sq.out_data !== 64'h0 || sq.out_keep !== 8'h00 || sq.out_last !== 1'b0) begin n_err++; $display("FAIL rst_out got %h/%h/%b want 0/00/0", sq.out_data, sq.out_keep, sq.out_last); end
    n_vec++; if ({done, more, mode_err} !== 3'b000 || state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_flags got %b st %0d want 000 st 0", {done, more, mode_err}, state_dbg); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sha3_256();
    start_load(3'd3);
    n_vec++; if (sq.load_ready !== 1'b0) begin n_err++; $display("FAIL s256_load_ready got %b want 0", sq.load_ready); end
    for (int w = 0; w < 4; w++) begin
      n_vec++; if (sq.out_valid !== 1'b1) begin n_err++; $display("FAIL s256_valid w%0d got %b want 1", w, sq.out_valid); end
      n_vec++; if (sq.out_data !== lane_val(w)) begin n_err++; $display("FAIL s256_data w%0d got %h want %h", w, sq.out_data, lane_val(w)); end
      n_vec++; if (sq.out_last !== (w == 3) || sq.out_keep !== 8'hFF) begin n_err++; $display("FAIL s256_last_keep w%0d got %b/%h want %b/ff", w, sq.out_last, sq.out_keep, (w == 3)); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL s256_early_done w%0d got %b want 0", w, done); end
      tick();
    end
    n_vec++; if (done !== 1'b1 || more !== 1'b0 || sq.out_valid !== 1'b0) begin n_err++; $display("FAIL s256_done got d%b m%b v%b want d1 m0 v0", done, more, sq.out_valid); end
    tick();
    n_vec++; if (done !== 1'b0 || sq.load_ready !== 1'b1) begin n_err++; $display("FAIL s256_idle got d%b lr%b want d0 lr1", done, sq.load_ready); end
  endtask

  task automatic test_sha3_224();
    logic [7:0] exp_keep;
    start_load(3'd0);
    for (int w = 0; w < 4; w++) begin
      exp_keep = (w == 3) ? 8'h0F : 8'hFF;
      n_vec++; if (sq.out_data !== lane_val(w)) begin n_err++; $display("FAIL s224_data w%0d got %h want %h", w, sq.out_data, lane_val(w)); end
      n_vec++; if (sq.out_keep !== exp_keep || sq.out_last !== (w == 3)) begin n_err++; $display("FAIL s224_keep w%0d got %h/%b want %h/%b", w, sq.out_keep, sq.out_last, exp_keep, (w == 3)); end
      tick();
    end
    n_vec++; if (done !== 1'b1 || more !== 1'b0) begin n_err++; $display("FAIL s224_done got d%b m%b want d1 m0", done, more); end
    tick();
  endtask

  task automatic test_shake128_backpressure();
    int  exp_idx;
    bit  fin;
    logic rdy;
    exp_idx = 0; fin = 0;
    start_load(3'd1);
    for (int c = 0; c < 80 && !fin; c++) begin
      n_vec++; if (sq.out_valid !== 1'b1 || sq.out_data !== lane_val(exp_idx)) begin n_err++; $display("FAIL s128_data c%0d got v%b %h want v1 %h", c, sq.out_valid, sq.out_data, lane_val(exp_idx)); end
      n_vec++; if (sq.out_last !== (exp_idx == 20) || sq.out_keep !== 8'hFF) begin n_err++; $display("FAIL s128_last c%0d got %b/%h want %b/ff", c, sq.out_last, sq.out_keep, (exp_idx == 20)); end
      rdy = (c % 2 == 0);
      sq.out_ready = rdy;
      tick();
      if (rdy) begin
        if (exp_idx == 20) fin = 1;
        else exp_idx++;
      end
    end
    n_vec++; if (!fin) begin n_err++; $display("FAIL s128_timeout got idx %0d want 20", exp_idx); end
    n_vec++; if (done !== 1'b1 || more !== 1'b1 || sq.out_valid !== 1'b0) begin n_err++; $display("FAIL s128_done got d%b m%b v%b want d1 m1 v0", done, more, sq.out_valid); end
    sq.out_ready = 1'b1;
    tick();
    n_vec++; if (more !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL s128_more_pulse got d%b m%b want d0 m0", done, more); end
  endtask

  task automatic test_load_ignored();
    start_load(3'd5);
    for (int w = 0; w < 8; w++) begin
      n_vec++; if (sq.out_data !== lane_val(w) || sq.out_last !== (w == 7)) begin n_err++; $display("FAIL s512_data w%0d got %h/%b want %h/%b", w, sq.out_data, sq.out_last, lane_val(w), (w == 7)); end
      if (w == 3) begin
        fill_state(64'hFFFF_FFFF_FFFF_FFFF);
        sq.c_mode = 3'd3;
        sq.load = 1'b1;
      end else begin
        sq.load = 1'b0;
      end
      tick();
    end
    sq.load = 1'b0;
    n_vec++; if (done !== 1'b1 || more !== 1'b0) begin n_err++; $display("FAIL s512_done got d%b m%b want d1 m0", done, more); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (sq.out_valid !== 1'b0 || sq.load_ready !== 1'b1) begin n_err++; $display("FAIL s512_extra c%0d got v%b lr%b want v0 lr1", c, sq.out_valid, sq.load_ready); end
    end
    fill_state(64'h0);
  endtask

  task automatic test_invalid_mode();
    start_load(3'd7);
    n_vec++; if (mode_err !== 1'b1) begin n_err++; $display("FAIL inv_mode_err got %b want 1", mode_err); end
    n_vec++; if (sq.out_valid !== 1'b0 || sq.load_ready !== 1'b1 || state_dbg !== 2'd0) begin n_err++; $display("FAIL inv_state got v%b lr%b st%0d want v0 lr1 st0", sq.out_valid, sq.load_ready, state_dbg); end
    tick();
    n_vec++; if (mode_err !== 1'b0 || sq.out_valid !== 1'b0) begin n_err++; $display("FAIL inv_pulse got e%b v%b want e0 v0", mode_err, sq.out_valid); end
  endtask

  task automatic test_reset_midstream();
    start_load(3'd2);
    for (int w = 0; w < 5; w++) tick();
    n_vec++; if (sq.out_data !== lane_val(5)) begin n_err++; $display("FAIL s256x_pre got %h want %h", sq.out_data, lane_val(5)); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (sq.out_valid !== 1'b0 || sq.out_data !== 64'h0 || sq.out_keep !== 8'h00 || sq.out_last !== 1'b0) begin n_err++; $display("FAIL arst_out got v%b %h/%h/%b want v0 0/00/0", sq.out_valid, sq.out_data, sq.out_keep, sq.out_last); end
    n_vec++; if (sq.load_ready !== 1'b1 || state_dbg !== 2'd0) begin n_err++; $display("FAIL arst_state got lr%b st%0d want lr1 st0", sq.load_ready, state_dbg); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (done !== 1'b0 || more !== 1'b0) begin n_err++; $display("FAIL arst_done c%0d got d%b m%b want d0 m0", c, done, more); end
    end
    rst_n = 1'b1;
    tick();
    start_load(3'd3);
    n_vec++; if (sq.out_valid !== 1'b1 || sq.out_data !== lane_val(0)) begin n_err++; $display("FAIL arst_reload w0 got v%b %h want v1 %h", sq.out_valid, sq.out_data, lane_val(0)); end
    tick();
    n_vec++; if (sq.out_data !== lane_val(1)) begin n_err++; $display("FAIL arst_reload w1 got %h want %h", sq.out_data, lane_val(1)); end
    for (int c = 0; c < 4; c++) tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_sha3_256();
    test_sha3_224();
    test_shake128_backpressure();
    test_load_ignored();
    test_invalid_mode();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
